sst_xfer_seq: RTL and testbench
===============================

# sst_xfer_seq

Save-state transfer sequencer. Walks the 2 KB save-state address window (mapper regs, sniffed PPU/APU regs, OAM, mapper memory) and streams it out byte-by-byte for a save, or streams bytes in and writes them back for a load. It owns the SST address/strobe bus on the `clk` side and yields it cycle-by-cycle to CPU-side SST register accesses. It sits between the PI-side streaming link and the SST controller's address/data mux.

## Interface
Parameters:
- `XFER_LEN`, 2048: bytes per transfer; addresses `0..XFER_LEN-1`.
- `RO_LO`, 13'h080: first read-only (sniffer/OAM) address.
- `RO_HI`, 13'h1FF: last read-only address.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `sys_rst_n`  in  1  asynchronous, active-low reset.
- `cmd_start`  in  1  one-cycle start request; sampled only in IDLE.
- `cmd_dir`  in  1  sampled with `cmd_start`; 0 = save (SST→tx), 1 = load (rx→SST).
- `cmd_abort`  in  1  returns the block to IDLE from any state.
- `cmd_busy`  out  1  high in every state except IDLE.
- `cmd_done`  out  1  one-cycle pulse on normal completion.
- `cpu_req`  in  1  CPU-side SST access this cycle; has priority over the engine.
- `cpu_gnt`  out  1  equals `cpu_req` (combinational); engine strobes are low whenever this is high.
- `sst_addr`  out  13  current transfer address.
- `sst_rd`  out  1  read strobe; `sst_rdat` is valid on the next cycle.
- `sst_we`  out  1  write strobe.
- `sst_wdat`  out  8  write data.
- `sst_rdat`  in  8  read data; 1-cycle latency.
- `tx_dat`  out  8  save-stream data.
- `tx_vld`  out  1  save-stream valid.
- `tx_rdy`  in  1  save-stream ready.
- `rx_dat`  in  8  load-stream data.
- `rx_vld`  in  1  load-stream valid.
- `rx_rdy`  out  1  load-stream ready.
- `byte_cnt`  out  12  bytes completed in the current or last transfer.
- `csum`  out  8  sum mod 256 of all bytes transferred.

## Operation
- Reset: state IDLE. All outputs 0, `sst_addr` = 0, `csum` = 0, `byte_cnt` = 0.
- `sst_addr` = `{2'b00, byte_cnt[10:0]}` while busy.
- IDLE:
  - On `cmd_start`: clear `byte_cnt` and `csum`, latch `cmd_dir`.
  - Save → RD. Load → RX.
  - `cmd_start` in any other state is ignored.
- Save path:
  - RD: if `!cpu_req`, assert `sst_rd` and go to CAP; otherwise stay in RD with strobes low.
  - CAP: latch `sst_rdat` into `tx_dat`, go to TX.
  - TX: `tx_vld` = 1, `tx_dat` held stable. On `tx_vld & tx_rdy`: add the byte to `csum`, increment `byte_cnt`. If the new count equals `XFER_LEN`, go to DONE; else go to RD.
- Load path:
  - RX: `rx_rdy` = 1. On `rx_vld & rx_rdy`: latch `rx_dat` into `sst_wdat`, add it to `csum`, go to WR.
  - WR: if `cpu_req`, stall with strobes low. Otherwise:
    - Assert `sst_we` unless `RO_LO <= sst_addr <= RO_HI`. Read-only bytes are consumed and counted but never written.
    - Increment `byte_cnt`. Go to DONE at `XFER_LEN`, else back to RX.
- DONE: `cmd_done` = 1 for one cycle, then IDLE. `byte_cnt` and `csum` hold until the next start.
- Abort:
  - `cmd_abort` in any busy state → IDLE next cycle, with no `cmd_done` and no strobes that cycle.
  - `byte_cnt` and `csum` freeze at their partial values.
  - Abort wins over a simultaneous handshake: that byte is not counted.
- `sst_rd`, `sst_we`, `tx_vld` and `rx_rdy` are never high outside their own states. `sst_rd` and `sst_we` are never high together.

## Timing
- All state, strobes and stream outputs are registered off `clk`, except `cpu_gnt` and the `cpu_req`-gating of `sst_rd`/`sst_we`, which are combinational.
- Save, `tx_rdy` tied high and no `cpu_req`: 3 cycles/byte (RD, CAP, TX). Full transfer = 6144 cycles from the first RD to the DONE state.
- Load, `rx_vld` tied high and no `cpu_req`: 2 cycles/byte (RX, WR). Full transfer = 4096 cycles.
- Each `cpu_req` cycle seen in RD or WR adds exactly one cycle of stall. `cpu_req` in CAP, TX or RX has no effect.
- `cmd_busy` rises the cycle after `cmd_start` and falls the cycle after `cmd_done`.
- Counter arithmetic:
  - `byte_cnt` is 12 bits and reaches exactly `XFER_LEN`; it never wraps.
  - `csum` wraps modulo 256.
- Asynchronous reset mid-transfer: all outputs go to their reset values immediately.

## Test plan
- Save, SST model with `data = addr[7:0] ^ 8'h5A`, `tx_rdy` = 1: 2048 tx bytes in address order, `cmd_done` at cycle 6144, `byte_cnt` = 2048, `csum` matches the model sum.
- Load of 2048 bytes, all `8'hA5`: `sst_we` asserted exactly 1664 times, never for addresses 0x080–0x1FF; `csum` = (2048·0xA5) mod 256 = 0x00.
- Save with `cpu_req` high for 5 cycles during RD at address 0x010: `sst_rd` low for those 5 cycles, `cpu_gnt` = 1, total completion time +5 cycles, data unaffected.
- Save with `tx_rdy` low for 10 cycles at byte 3: `tx_dat` stable, `byte_cnt` stays 3, then resumes.
- `cmd_abort` asserted in the same cycle as the handshake on byte 100 of a load: IDLE next cycle, `byte_cnt` = 100, no `cmd_done`; a fresh `cmd_start` restarts at address 0.
- `cmd_start` pulsed while busy: ignored. `sys_rst_n` asserted mid-save: all outputs 0 immediately, state IDLE.

Source files
------------

// File: rtl/sst_xfer_seq.sv
// rtl/sst_xfer_seq.sv - save-state transfer sequencer
// Streams the SST window out for a save or writes a stream back for a load.
module sst_xfer_seq #(
  parameter int          XFER_LEN = 2048,
  parameter logic [12:0] RO_LO    = 13'h080,
  parameter logic [12:0] RO_HI    = 13'h1FF
) (
  input  logic        clk,
  input  logic        sys_rst_n,
  input  logic        cmd_start,
  input  logic        cmd_dir,
  input  logic        cmd_abort,
  output logic        cmd_busy,
  output logic        cmd_done,
  input  logic        cpu_req,
  output logic        cpu_gnt,
  output logic [12:0] sst_addr,
  output logic        sst_rd,
  output logic        sst_we,
  output logic [7:0]  sst_wdat,
  input  logic [7:0]  sst_rdat,
  output logic [7:0]  tx_dat,
  output logic        tx_vld,
  input  logic        tx_rdy,
  input  logic [7:0]  rx_dat,
  input  logic        rx_vld,
  output logic        rx_rdy,
  output logic [11:0] byte_cnt,
  output logic [7:0]  csum
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_CAP, S_TX, S_RX, S_WR, S_DONE
  } state_t;

  state_t      state, state_nxt;
  logic [11:0] cnt_q, cnt_nxt;
  logic [7:0]  csum_q, csum_nxt;
  logic [7:0]  txd_q, txd_nxt;
  logic [7:0]  wd_q, wd_nxt;
  logic        rd_en, we_en;
  logic        last_byte, ro_addr;

  assign cmd_busy  = (state != S_IDLE);
  assign cmd_done  = (state == S_DONE);
  assign tx_vld    = (state == S_TX);
  assign rx_rdy    = (state == S_RX);
  assign cpu_gnt   = cpu_req;
  assign sst_addr  = cmd_busy ? {2'b00, cnt_q[10:0]} : 13'd0;
  assign sst_rd    = rd_en;
  assign sst_we    = we_en;
  assign sst_wdat  = wd_q;
  assign tx_dat    = txd_q;
  assign byte_cnt  = cnt_q;
  assign csum      = csum_q;
  assign last_byte = ((cnt_q + 12'd1) == 12'(XFER_LEN));
  assign ro_addr   = (sst_addr >= RO_LO) && (sst_addr <= RO_HI);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt_q;
    csum_nxt  = csum_q;
    txd_nxt   = txd_q;
    wd_nxt    = wd_q;
    rd_en     = 1'b0;
    we_en     = 1'b0;
    // Abort beats any handshake or strobe in the same cycle.
    if (cmd_busy && cmd_abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_start) begin
            cnt_nxt   = 12'd0;
            csum_nxt  = 8'd0;
            state_nxt = cmd_dir ? S_RX : S_RD;
          end
        end
        S_RD: begin
          if (!cpu_req) begin
            rd_en     = 1'b1;
            state_nxt = S_CAP;
          end
        end
        S_CAP: begin
          txd_nxt   = sst_rdat;
          state_nxt = S_TX;
        end
        S_TX: begin
          if (tx_rdy) begin
            csum_nxt  = csum_q + txd_q;
            cnt_nxt   = cnt_q + 12'd1;
            state_nxt = last_byte ? S_DONE : S_RD;
          end
        end
        S_RX: begin
          if (rx_vld) begin
            wd_nxt    = rx_dat;
            csum_nxt  = csum_q + rx_dat;
            state_nxt = S_WR;
          end
        end
        S_WR: begin
          if (!cpu_req) begin
            we_en     = !ro_addr;
            cnt_nxt   = cnt_q + 12'd1;
            state_nxt = last_byte ? S_DONE : S_RX;
          end
        end
        S_DONE:  state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state  <= S_IDLE;
      cnt_q  <= 12'd0;
      csum_q <= 8'd0;
      txd_q  <= 8'd0;
      wd_q   <= 8'd0;
    end else begin
      state  <= state_nxt;
      cnt_q  <= cnt_nxt;
      csum_q <= csum_nxt;
      txd_q  <= txd_nxt;
      wd_q   <= wd_nxt;
    end
  end

endmodule

// File: tb/tb_sst_xfer_seq.sv
// tb/tb_sst_xfer_seq.sv - scoreboard bench for sst_xfer_seq
// Driver pushes expected tx bytes / SST writes; a negedge monitor pops and compares.
module tb_sst_xfer_seq;

  logic        clk = 1'b0;
  logic        sys_rst_n;
  logic        cmd_start, cmd_dir, cmd_abort;
  logic        cmd_busy, cmd_done;
  logic        cpu_req, cpu_gnt;
  logic [12:0] sst_addr;
  logic        sst_rd, sst_we;
  logic [7:0]  sst_wdat, sst_rdat;
  logic [7:0]  tx_dat;
  logic        tx_vld, tx_rdy;
  logic [7:0]  rx_dat;
  logic        rx_vld, rx_rdy;
  logic [11:0] byte_cnt;
  logic [7:0]  csum;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int start_cyc = 0;
  int we_cnt = 0;
  int rd_cnt = 0;
  int done_cnt = 0;
  logic [7:0]  exp_tx[$];
  logic [20:0] exp_wr[$];

  sst_xfer_seq dut (
    .clk(clk), .sys_rst_n(sys_rst_n),
    .cmd_start(cmd_start), .cmd_dir(cmd_dir), .cmd_abort(cmd_abort),
    .cmd_busy(cmd_busy), .cmd_done(cmd_done),
    .cpu_req(cpu_req), .cpu_gnt(cpu_gnt),
    .sst_addr(sst_addr), .sst_rd(sst_rd), .sst_we(sst_we),
    .sst_wdat(sst_wdat), .sst_rdat(sst_rdat),
    .tx_dat(tx_dat), .tx_vld(tx_vld), .tx_rdy(tx_rdy),
    .rx_dat(rx_dat), .rx_vld(rx_vld), .rx_rdy(rx_rdy),
    .byte_cnt(byte_cnt), .csum(csum)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // SST memory model: data = addr[7:0] ^ 8'h5A, one cycle read latency.
  always @(posedge clk) begin
    if (sst_rd) sst_rdat <= sst_addr[7:0] ^ 8'h5A;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sys_rst_n) begin
      if (tx_vld && tx_rdy) begin
        if (exp_tx.size() == 0) check("tx_unexpected", 32'(tx_dat), 32'hFFFF_FFFF);
        else check("tx_dat", 32'(tx_dat), 32'(exp_tx.pop_front()));
      end
      if (sst_we) begin
        we_cnt++;
        if (exp_wr.size() == 0) check("wr_unexpected", 32'({sst_addr, sst_wdat}), 32'hFFFF_FFFF);
        else check("wr_addr_data", 32'({sst_addr, sst_wdat}), 32'(exp_wr.pop_front()));
      end
      if (sst_rd && sst_we) check("rd_we_overlap", 32'd1, 32'd0);
      if (sst_rd) rd_cnt++;
      if (cpu_req) check("cpu_gnt_strobes", 32'({cpu_gnt, sst_rd, sst_we}), 32'b100);
      if (cmd_done) done_cnt++;
    end
  end

  task automatic start(input logic dir);
    cmd_dir   = dir;
    cmd_start = 1'b1;
    start_cyc = cyc;
    @(posedge clk); #1;
    cmd_start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int exp_lat);
    bit seen = 0;
    for (int i = 0; i < 8000 && !seen; i++) begin
      @(negedge clk);
      if (cmd_done) seen = 1;
    end
    if (!seen) check({name, "_timeout"}, 32'd0, 32'd1);
    else check({name, "_latency"}, 32'(cyc - start_cyc - 1), 32'(exp_lat));
    @(posedge clk); #1;
  endtask

  task automatic push_save(output logic [7:0] sum);
    sum = 8'd0;
    for (int a = 0; a < 2048; a++) begin
      logic [10:0] aa;
      aa = 11'(a);
      exp_tx.push_back(aa[7:0] ^ 8'h5A);
      sum = sum + (aa[7:0] ^ 8'h5A);
    end
  endtask

  task automatic wait_tx_hs(input int n);
    bit seen = 0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(negedge clk);
      if (tx_vld && tx_rdy && byte_cnt == 12'(n)) seen = 1;
    end
    if (!seen) check("tx_hs_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [7:0] exp_sum;
    int wc0, dc0;
    bit seen;
    sys_rst_n = 1'b0; cmd_start = 0; cmd_dir = 0; cmd_abort = 0;
    cpu_req = 0; tx_rdy = 1; rx_vld = 0; rx_dat = 8'hA5;
    repeat (3) @(posedge clk);
    #1 sys_rst_n = 1'b1;
    @(posedge clk); #1;

    check("rst_busy", 32'(cmd_busy), 32'd0);
    check("rst_addr", 32'(sst_addr), 32'd0);
    check("rst_cnt_csum", 32'({byte_cnt, csum}), 32'd0);
    check("rst_strobes", 32'({sst_rd, sst_we, tx_vld, rx_rdy, cmd_done}), 32'd0);

    // Full save with a stray start mid-transfer.
    push_save(exp_sum);
    start(1'b0);
    check("busy_after_start", 32'(cmd_busy), 32'd1);
    repeat (50) @(posedge clk);
    #1 cmd_dir = 1'b1; cmd_start = 1'b1;
    @(posedge clk); #1 cmd_start = 1'b0;
    wait_done("save", 6144);
    check("save_cnt", 32'(byte_cnt), 32'd2048);
    check("save_csum", 32'(csum), 32'(exp_sum));
    check("save_queue_empty", 32'(exp_tx.size()), 32'd0);
    check("save_busy_fall", 32'(cmd_busy), 32'd0);

    // Full load of 0xA5; read-only window must not be written.
    for (int a = 0; a < 2048; a++)
      if (a < 'h80 || a > 'h1FF) exp_wr.push_back({13'(a), 8'hA5});
    wc0 = we_cnt;
    rx_vld = 1'b1;
    start(1'b1);
    wait_done("load", 4096);
    rx_vld = 1'b0;
    check("load_we_count", 32'(we_cnt - wc0), 32'd1664);
    check("load_cnt", 32'(byte_cnt), 32'd2048);
    check("load_csum", 32'(csum), 32'h00);
    check("load_queue_empty", 32'(exp_wr.size()), 32'd0);

    // Save with cpu_req held 5 cycles in RD at address 0x010.
    push_save(exp_sum);
    start(1'b0);
    wait_tx_hs(15);
    check("cpu_stall_addr", 32'(sst_addr), 32'h010);
    cpu_req = 1'b1;
    repeat (5) begin @(posedge clk); #1; end
    cpu_req = 1'b0;
    wait_done("save_cpu", 6149);
    check("save_cpu_csum", 32'(csum), 32'(exp_sum));

    // Save with tx_rdy low for 10 TX cycles at byte 3.
    push_save(exp_sum);
    start(1'b0);
    wait_tx_hs(2);
    @(posedge clk); @(posedge clk); #1;
    tx_rdy = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 0 || i == 9) begin
        check("txstall_dat", 32'(tx_dat), 32'h59);
        check("txstall_cnt_vld", 32'({byte_cnt, tx_vld}), 32'({12'd3, 1'b1}));
      end
      @(posedge clk); #1;
    end
    tx_rdy = 1'b1;
    wait_done("save_txstall", 6154);

    // Abort on the byte-100 handshake of a load.
    for (int a = 0; a < 100; a++) exp_wr.push_back({13'(a), 8'hA5});
    dc0 = done_cnt;
    rx_vld = 1'b1;
    start(1'b1);
    seen = 0;
    for (int i = 0; i < 1000 && !seen; i++) begin
      @(negedge clk);
      if (sst_we && sst_addr == 13'd99) seen = 1;
    end
    if (!seen) check("abort_wait_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    check("abort_rx_rdy", 32'(rx_rdy), 32'd1);
    cmd_abort = 1'b1;
    @(posedge clk); #1 cmd_abort = 1'b0;
    check("abort_busy", 32'(cmd_busy), 32'd0);
    check("abort_cnt", 32'(byte_cnt), 32'd100);
    check("abort_csum", 32'(csum), 32'h74);
    check("abort_no_done", 32'(done_cnt - dc0), 32'd0);

    // Fresh start restarts at address 0; abort in WR suppresses the write.
    start(1'b1);
    check("restart_addr", 32'(sst_addr), 32'd0);
    check("restart_cnt_csum", 32'({byte_cnt, csum}), 32'd0);
    @(posedge clk); #1 cmd_abort = 1'b1;
    @(posedge clk); #1 cmd_abort = 1'b0;
    rx_vld = 1'b0;
    check("abort_wr_cnt", 32'(byte_cnt), 32'd0);
    check("abort_wr_csum", 32'(csum), 32'hA5);
    check("abort_wr_busy", 32'(cmd_busy), 32'd0);

    // Asynchronous reset in the middle of a save.
    push_save(exp_sum);
    start(1'b0);
    repeat (20) @(posedge clk);
    #1 sys_rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(cmd_busy), 32'd0);
    check("arst_addr", 32'(sst_addr), 32'd0);
    check("arst_cnt_csum", 32'({byte_cnt, csum}), 32'd0);
    check("arst_outs", 32'({sst_rd, sst_we, tx_vld, rx_rdy, cmd_done, tx_dat, sst_wdat}), 32'd0);
    exp_tx.delete();
    @(posedge clk); #1 sys_rst_n = 1'b1;
    @(posedge clk); #1;
    check("arst_after_busy", 32'(cmd_busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
